// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: issue, completion, flush and retirement signals.
// storeCommit/storeCommitTag exist only when ROB_STORE_COMMIT_EN is defined.
interface reorder_buffer_if;
    typedef struct packed {
        logic        confirm;
        logic [31:0] programCounter;
        logic [4:0]  destinationRegister;
        logic [3:0]  ageTag;
        logic        isStore;
    } IssuedIntruction_;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ageTag;
        logic [31:0] instructionResult;
    } InputInstruction_;

    typedef struct packed {
        logic        valid;
        logic [31:0] instructionResult;
        logic [4:0]  destinationRegister;
    } RetiredInstruction_;

    IssuedIntruction_   issued;
    logic               allocateReady;
    logic [3:0]         nextAgeTag;
    InputInstruction_   upperResult;
    InputInstruction_   lowerResult;
    logic               flush;
    RetiredInstruction_ retired;
`ifdef ROB_STORE_COMMIT_EN
    logic               storeCommit;
    logic [3:0]         storeCommitTag;
`endif

    modport master (
        output issued, upperResult, lowerResult, flush,
        input  allocateReady, nextAgeTag, retired
`ifdef ROB_STORE_COMMIT_EN
        , input storeCommit, storeCommitTag
`endif
    );

    modport slave (
        input  issued, upperResult, lowerResult, flush,
        output allocateReady, nextAgeTag, retired
`ifdef ROB_STORE_COMMIT_EN
        , output storeCommit, storeCommitTag
`endif
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer with two completion ports.
// Optional store-commit pulse enabled by defining ROB_STORE_COMMIT_EN.
module reorder_buffer #(
    parameter int DEPTH = 16
) (
    input logic             clock,
    input logic             reset,
    reorder_buffer_if.slave rob
);
    typedef struct packed {
        logic [31:0] programCounter;
        logic [31:0] instructionResult;
        logic [4:0]  destinationRegister;
        logic [3:0]  ageTag;
        logic        isStore;
        logic        resultsReady;
    } QueueEntry_;

    localparam logic [4:0] FULL_COUNT = 5'(DEPTH);

    QueueEntry_       slot_r [DEPTH];
    logic [DEPTH-1:0] occupied_r;
    logic [3:0]       head_r;
    logic [3:0]       tail_r;
    logic [4:0]       count_r;
    logic             retired_valid_r;
    logic [31:0]      retired_result_r;
    logic [4:0]       retired_rd_r;
`ifdef ROB_STORE_COMMIT_EN
    logic             store_commit_r;
    logic [3:0]       store_commit_tag_r;
`endif

    logic alloc_s;
    logic retire_s;
    logic retire_write_s;
    logic upper_hit_s;
    logic lower_hit_s;

    // Handshake qualification and head retirement decision from current state
    always_comb begin
        alloc_s        = rob.issued.confirm && (count_r < FULL_COUNT);
        retire_s       = (count_r != 5'd0) && occupied_r[head_r] && slot_r[head_r].resultsReady;
        retire_write_s = retire_s && !slot_r[head_r].isStore
                         && (slot_r[head_r].destinationRegister != 5'd0);
        upper_hit_s    = rob.upperResult.valid && occupied_r[rob.upperResult.ageTag];
        lower_hit_s    = rob.lowerResult.valid && occupied_r[rob.lowerResult.ageTag];
    end

    // Queue state, completion writeback and registered retirement outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r           <= 4'd0;
            tail_r           <= 4'd0;
            count_r          <= 5'd0;
            occupied_r       <= '0;
            retired_valid_r  <= 1'b0;
            retired_result_r <= 32'd0;
            retired_rd_r     <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= '0;
            end
`ifdef ROB_STORE_COMMIT_EN
            store_commit_r     <= 1'b0;
            store_commit_tag_r <= 4'd0;
`endif
        end else if (rob.flush) begin
            head_r          <= 4'd0;
            tail_r          <= 4'd0;
            count_r         <= 5'd0;
            occupied_r      <= '0;
            retired_valid_r <= 1'b0;
`ifdef ROB_STORE_COMMIT_EN
            store_commit_r  <= 1'b0;
`endif
        end else begin
            retired_valid_r <= retire_write_s;
`ifdef ROB_STORE_COMMIT_EN
            store_commit_r  <= retire_s && slot_r[head_r].isStore;
            if (retire_s && slot_r[head_r].isStore) begin
                store_commit_tag_r <= slot_r[head_r].ageTag;
            end
`endif
            // Lower written first so upper wins a same-tag collision
            if (lower_hit_s) begin
                slot_r[rob.lowerResult.ageTag].instructionResult <= rob.lowerResult.instructionResult;
                slot_r[rob.lowerResult.ageTag].resultsReady      <= 1'b1;
            end
            if (upper_hit_s) begin
                slot_r[rob.upperResult.ageTag].instructionResult <= rob.upperResult.instructionResult;
                slot_r[rob.upperResult.ageTag].resultsReady      <= 1'b1;
            end
            if (retire_s) begin
                head_r                       <= head_r + 4'd1;
                occupied_r[head_r]           <= 1'b0;
                slot_r[head_r].resultsReady  <= 1'b0;
                retired_result_r             <= slot_r[head_r].instructionResult;
                retired_rd_r                 <= slot_r[head_r].destinationRegister;
            end
            if (alloc_s) begin
                slot_r[tail_r] <= '{programCounter:      rob.issued.programCounter,
                                    instructionResult:   32'd0,
                                    destinationRegister: rob.issued.destinationRegister,
                                    ageTag:              tail_r,
                                    isStore:             rob.issued.isStore,
                                    resultsReady:        1'b0};
                occupied_r[tail_r] <= 1'b1;
                tail_r             <= tail_r + 4'd1;
            end
            count_r <= count_r + {4'd0, alloc_s} - {4'd0, retire_s};
        end
    end

    assign rob.allocateReady                 = (count_r < FULL_COUNT);
    assign rob.nextAgeTag                    = tail_r;
    assign rob.retired.valid                 = retired_valid_r;
    assign rob.retired.instructionResult     = retired_result_r;
    assign rob.retired.destinationRegister   = retired_rd_r;
`ifdef ROB_STORE_COMMIT_EN
    assign rob.storeCommit                   = store_commit_r;
    assign rob.storeCommitTag                = store_commit_tag_r;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, corner sequences,
// and randomized traffic against a queue-based model of in-order retirement.
module tb_reorder_buffer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    reorder_buffer_if bus ();
    reorder_buffer #(.DEPTH(16)) dut (.clock(clock), .reset(reset), .rob(bus));

    typedef struct {
        bit rst; bit flush; bit confirm; bit [31:0] pc; bit [4:0] rd; bit st;
        bit uv; bit [3:0] ut; bit [31:0] ur; bit lv; bit [3:0] lt; bit [31:0] lr;
    } in_t;
    typedef struct {
        in_t i; bit rdy; bit [3:0] tag; bit rv; bit [31:0] res; bit [4:0] rd;
    } row_t;

    int n_cmp = 0;
    int n_bad = 0;
    row_t tbl[$];

    // Reference model: program-order queue of tags plus per-tag contents
    int        m_q[$];
    bit        m_occ[16];
    bit        m_rdy[16];
    bit [31:0] m_res[16];
    bit [4:0]  m_rd[16];
    bit        m_st[16];
    int        m_next = 0;
    bit        m_rv = 0;
    bit        m_sc = 0;
    bit [31:0] m_eres;
    bit [4:0]  m_erd;
    bit [3:0]  m_sctag = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t f_idle();
        in_t r;
        r = '{default: 0};
        return r;
    endfunction
    function automatic in_t f_rst();
        in_t r = f_idle(); r.rst = 1'b1; return r;
    endfunction
    function automatic in_t f_alloc(input bit [31:0] pc, input bit [4:0] rd, input bit st);
        in_t r = f_idle(); r.confirm = 1'b1; r.pc = pc; r.rd = rd; r.st = st; return r;
    endfunction
    function automatic in_t f_up(input bit [3:0] t, input bit [31:0] v);
        in_t r = f_idle(); r.uv = 1'b1; r.ut = t; r.ur = v; return r;
    endfunction
    function automatic in_t f_lo(input bit [3:0] t, input bit [31:0] v);
        in_t r = f_idle(); r.lv = 1'b1; r.lt = t; r.lr = v; return r;
    endfunction
    function automatic in_t f_two(input bit [3:0] ut, input bit [31:0] uv, input bit [3:0] lt, input bit [31:0] lv);
        in_t r = f_up(ut, uv); r.lv = 1'b1; r.lt = lt; r.lr = lv; return r;
    endfunction

    task automatic add(input in_t i, input bit rdy, input bit [3:0] tag, input bit rv,
                       input bit [31:0] res, input bit [4:0] rd);
        row_t r;
        r.i = i; r.rdy = rdy; r.tag = tag; r.rv = rv; r.res = res; r.rd = rd;
        tbl.push_back(r);
    endtask

    task automatic model_step(input in_t i);
        bit can_alloc;
        int t;
        if (i.rst || i.flush) begin
            m_q.delete();
            foreach (m_occ[k]) m_occ[k] = 1'b0;
            m_next = 0; m_rv = 1'b0; m_sc = 1'b0;
            if (i.rst) m_sctag = 4'd0;
        end else begin
            can_alloc = i.confirm && (m_q.size() < 16);
            m_rv = 1'b0; m_sc = 1'b0;
            if (m_q.size() > 0 && m_rdy[m_q[0]]) begin
                t = m_q.pop_front();
                m_occ[t] = 1'b0;
                m_rv   = !m_st[t] && (m_rd[t] != 5'd0);
                m_eres = m_res[t];
                m_erd  = m_rd[t];
                if (m_st[t]) begin m_sc = 1'b1; m_sctag = 4'(t); end
            end
            if (i.lv && m_occ[i.lt]) begin m_res[i.lt] = i.lr; m_rdy[i.lt] = 1'b1; end
            if (i.uv && m_occ[i.ut]) begin m_res[i.ut] = i.ur; m_rdy[i.ut] = 1'b1; end
            if (can_alloc) begin
                m_q.push_back(m_next);
                m_occ[m_next] = 1'b1; m_rdy[m_next] = 1'b0;
                m_rd[m_next] = i.rd;  m_st[m_next] = i.st;
                m_next = (m_next + 1) % 16;
            end
        end
    endtask

    task automatic apply(input in_t i);
        reset                               = i.rst;
        bus.flush                           = i.flush;
        bus.issued.confirm                  = i.confirm;
        bus.issued.programCounter           = i.pc;
        bus.issued.destinationRegister      = i.rd;
        bus.issued.ageTag                   = 4'(m_next);
        bus.issued.isStore                  = i.st;
        bus.upperResult.valid               = i.uv;
        bus.upperResult.ageTag              = i.ut;
        bus.upperResult.instructionResult   = i.ur;
        bus.lowerResult.valid               = i.lv;
        bus.lowerResult.ageTag              = i.lt;
        bus.lowerResult.instructionResult   = i.lr;
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, " allocateReady"}, 32'(bus.allocateReady), 32'(m_q.size() < 16));
        chk({ctx, " nextAgeTag"}, 32'(bus.nextAgeTag), 32'(m_next));
        chk({ctx, " retired.valid"}, 32'(bus.retired.valid), 32'(m_rv));
        if (m_rv) begin
            chk({ctx, " retired.result"}, bus.retired.instructionResult, m_eres);
            chk({ctx, " retired.rd"}, 32'(bus.retired.destinationRegister), 32'(m_erd));
        end
`ifdef ROB_STORE_COMMIT_EN
        chk({ctx, " storeCommit"}, 32'(bus.storeCommit), 32'(m_sc));
        if (m_sc) chk({ctx, " storeCommitTag"}, 32'(bus.storeCommitTag), 32'(m_sctag));
`endif
    endtask

    task automatic cycle(input in_t i, input string ctx);
        apply(i);
        @(posedge clock);
        #1;
        model_step(i);
        apply(f_idle());
        check_model(ctx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t r;
        bit found;
        apply(f_rst());

        // Directed vectors: basic latency, in-order retire, port priority, rd=0, stray completion
        add(f_rst(),                      1'b1, 4'd0, 1'b0, 32'h0, 5'd0);
        add(f_alloc(32'h100, 5'd5, 1'b0), 1'b1, 4'd1, 1'b0, 32'h0, 5'd0);
        add(f_up(4'd0, 32'hDEADBEEF),     1'b1, 4'd1, 1'b0, 32'h0, 5'd0);
        add(f_idle(),                     1'b1, 4'd1, 1'b1, 32'hDEADBEEF, 5'd5);
        add(f_idle(),                     1'b1, 4'd1, 1'b0, 32'h0, 5'd0);
        add(f_rst(),                      1'b1, 4'd0, 1'b0, 32'h0, 5'd0);
        add(f_alloc(32'h200, 5'd1, 1'b0), 1'b1, 4'd1, 1'b0, 32'h0, 5'd0);
        add(f_alloc(32'h204, 5'd2, 1'b0), 1'b1, 4'd2, 1'b0, 32'h0, 5'd0);
        add(f_alloc(32'h208, 5'd3, 1'b0), 1'b1, 4'd3, 1'b0, 32'h0, 5'd0);
        add(f_up(4'd2, 32'hC2),           1'b1, 4'd3, 1'b0, 32'h0, 5'd0);
        add(f_lo(4'd1, 32'hC1),           1'b1, 4'd3, 1'b0, 32'h0, 5'd0);
        add(f_up(4'd0, 32'hC0),           1'b1, 4'd3, 1'b0, 32'h0, 5'd0);
        add(f_idle(),                     1'b1, 4'd3, 1'b1, 32'hC0, 5'd1);
        add(f_idle(),                     1'b1, 4'd3, 1'b1, 32'hC1, 5'd2);
        add(f_idle(),                     1'b1, 4'd3, 1'b1, 32'hC2, 5'd3);
        add(f_alloc(32'h20C, 5'd7, 1'b0), 1'b1, 4'd4, 1'b0, 32'h0, 5'd0);
        add(f_two(4'd3, 32'h11, 4'd3, 32'h22), 1'b1, 4'd4, 1'b0, 32'h0, 5'd0);
        add(f_idle(),                     1'b1, 4'd4, 1'b1, 32'h11, 5'd7);
        add(f_idle(),                     1'b1, 4'd4, 1'b0, 32'h0, 5'd0);
        add(f_up(4'd9, 32'h99),           1'b1, 4'd4, 1'b0, 32'h0, 5'd0);
        add(f_idle(),                     1'b1, 4'd4, 1'b0, 32'h0, 5'd0);
        add(f_alloc(32'h210, 5'd0, 1'b0), 1'b1, 4'd5, 1'b0, 32'h0, 5'd0);
        add(f_lo(4'd4, 32'h44),           1'b1, 4'd5, 1'b0, 32'h0, 5'd0);
        add(f_idle(),                     1'b1, 4'd5, 1'b0, 32'h0, 5'd0);
        add(f_alloc(32'h214, 5'd6, 1'b0), 1'b1, 4'd6, 1'b0, 32'h0, 5'd0);
        add(f_up(4'd5, 32'h55),           1'b1, 4'd6, 1'b0, 32'h0, 5'd0);
        add(f_idle(),                     1'b1, 4'd6, 1'b1, 32'h55, 5'd6);

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].i, $sformatf("row%0d model", k));
            chk($sformatf("row%0d allocateReady", k), 32'(bus.allocateReady), 32'(tbl[k].rdy));
            chk($sformatf("row%0d nextAgeTag", k), 32'(bus.nextAgeTag), 32'(tbl[k].tag));
            chk($sformatf("row%0d retired.valid", k), 32'(bus.retired.valid), 32'(tbl[k].rv));
            if (tbl[k].rv) begin
                chk($sformatf("row%0d retired.result", k), bus.retired.instructionResult, tbl[k].res);
                chk($sformatf("row%0d retired.rd", k), 32'(bus.retired.destinationRegister), 32'(tbl[k].rd));
            end
        end

        // Full queue: 17th confirm ignored, retire frees a slot, tail wraps to tag 0
        cycle(f_rst(), "full reset");
        for (int k = 0; k < 16; k++) cycle(f_alloc(32'h1000 + 32'(k * 4), 5'(k + 1), 1'b0), "fill");
        chk("full allocateReady", 32'(bus.allocateReady), 32'd0);
        chk("full nextAgeTag", 32'(bus.nextAgeTag), 32'd0);
        cycle(f_alloc(32'hBAD0, 5'd9, 1'b0), "17th confirm");
        chk("17th ignored nextAgeTag", 32'(bus.nextAgeTag), 32'd0);
        chk("17th ignored allocateReady", 32'(bus.allocateReady), 32'd0);
        cycle(f_up(4'd0, 32'hA0), "full complete head");
        cycle(f_idle(), "full retire");
        chk("after retire allocateReady", 32'(bus.allocateReady), 32'd1);
        chk("after retire retired.result", bus.retired.instructionResult, 32'hA0);
        cycle(f_alloc(32'h3000, 5'd10, 1'b0), "wrap alloc");
        chk("wrap nextAgeTag", 32'(bus.nextAgeTag), 32'd1);
        chk("wrap refilled allocateReady", 32'(bus.allocateReady), 32'd0);

        // Store entry at tag 4 retires without a register write
        cycle(f_rst(), "store reset");
        for (int k = 0; k < 4; k++) cycle(f_alloc(32'h400 + 32'(k * 4), 5'(k + 1), 1'b0), "store pre");
        cycle(f_alloc(32'h410, 5'd8, 1'b1), "store alloc");
        cycle(f_two(4'd0, 32'hB0, 4'd1, 32'hB1), "store c01");
        cycle(f_two(4'd2, 32'hB2, 4'd3, 32'hB3), "store c23");
        cycle(f_up(4'd4, 32'h5707E), "store c4");
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            cycle(f_idle(), "store drain");
`ifdef ROB_STORE_COMMIT_EN
            if (bus.storeCommit) begin
                found = 1'b1;
                chk("store storeCommitTag", 32'(bus.storeCommitTag), 32'd4);
                chk("store retired.valid", 32'(bus.retired.valid), 32'd0);
                cycle(f_idle(), "store after");
                chk("store pulse one cycle", 32'(bus.storeCommit), 32'd0);
            end
`else
            if (bus.nextAgeTag == 4'd5 && m_q.size() == 0) found = 1'b1;
`endif
        end
        chk("store retirement seen", 32'(found), 32'd1);

        // Flush with eight in flight and concurrent allocate/complete/retire
        cycle(f_rst(), "flush reset");
        for (int k = 0; k < 8; k++) cycle(f_alloc(32'h500 + 32'(k * 4), 5'(k + 1), 1'b0), "flush fill");
        cycle(f_up(4'd0, 32'hF0), "flush complete head");
        r = f_alloc(32'h600, 5'd12, 1'b0);
        r.flush = 1'b1; r.lv = 1'b1; r.lt = 4'd3; r.lr = 32'hF3;
        cycle(r, "flush");
        chk("flush nextAgeTag", 32'(bus.nextAgeTag), 32'd0);
        chk("flush allocateReady", 32'(bus.allocateReady), 32'd1);
        chk("flush retired.valid", 32'(bus.retired.valid), 32'd0);
        cycle(f_up(4'd3, 32'hF3), "post flush stray");
        for (int k = 0; k < 5; k++) begin
            cycle(f_idle(), "post flush idle");
            chk("post flush no retire", 32'(bus.retired.valid), 32'd0);
        end

        // Randomized traffic; odd blocks starve completions to drive the queue full
        for (int blk = 0; blk < 6; blk++) begin
            int cp;
            cp = (blk % 2 == 1) ? 10 : 60;
            for (int c = 0; c < 150; c++) begin
                r = f_idle();
                r.confirm = ($urandom_range(0, 99) < 60);
                r.pc      = $urandom;
                r.rd      = 5'($urandom_range(0, 31));
                r.st      = ($urandom_range(0, 3) == 0);
                r.uv      = ($urandom_range(0, 99) < cp);
                r.ut      = (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                            ? 4'(m_q[$urandom_range(0, m_q.size() - 1)]) : 4'($urandom_range(0, 15));
                r.ur      = $urandom;
                r.lv      = ($urandom_range(0, 99) < cp);
                r.lt      = (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                            ? 4'(m_q[$urandom_range(0, m_q.size() - 1)]) : 4'($urandom_range(0, 15));
                r.lr      = $urandom;
                r.flush   = ($urandom_range(0, 199) == 0);
                r.rst     = ($urandom_range(0, 499) == 0);
                cycle(r, $sformatf("rand b%0d c%0d", blk, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; fixed equal to the 2^4 ageTag space.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issued  input  IssuedIntruction_  allocation request from issuer; confirm is the request strobe.
REQ-005 SHALL have port allocateReady  output  1  high when count < DEPTH.
REQ-006 SHALL have port nextAgeTag  output  4  tail index; issuer SHALL stamp this value into issued.ageTag.
REQ-007 SHALL have port upperResult  input  InputInstruction_  completion from upper (memory-capable) slot.
REQ-008 SHALL have port lowerResult  input  InputInstruction_  completion from lower slot.
REQ-009 SHALL have port flush  input  1  discard all entries.
REQ-010 SHALL have port retired  output  RetiredInstruction_  registered write to register file.
REQ-011 SHALL have ports storeCommit  output  1 and storeCommitTag  output  4, present only under ROB_STORE_COMMIT_EN.

Function
REQ-012 SHALL hold DEPTH QueueEntry_ slots plus per-slot occupied bit, 4-bit head, 4-bit tail, 5-bit count.
REQ-013 SHALL allocate when issued.confirm && count < DEPTH: slot[tail] <= {programCounter, 0, destinationRegister, tail, isStore, resultsReady=0}, occupied=1, tail+1 mod 16.
REQ-014 SHALL ignore issued.confirm while count == DEPTH (no state change, no error).
REQ-015 SHALL, on result.valid with slot[ageTag] occupied, write instructionResult and set resultsReady, taking effect next cycle.
REQ-016 SHALL ignore completions to unoccupied slots; if both ports hit the same tag in one cycle, upperResult SHALL win.
REQ-017 SHALL retire at most one entry per cycle: when count > 0 and slot[head].resultsReady, head+1 mod 16, slot cleared, retired registered next cycle.
REQ-018 SHALL drive retired.valid=1 only for non-store entries with destinationRegister != 0; otherwise retired.valid=0 while head still advances.
REQ-019 SHALL drive retired.valid=0 in any cycle following no retirement; data fields SHALL hold last value.
REQ-020 SHALL give completion-to-retire latency of 2 cycles for a head entry (complete at N, retired.valid at N+2).
REQ-021 SHALL compute allocateReady from pre-update count; simultaneous allocate and retire SHALL leave count unchanged.
REQ-022 SHALL wrap head and tail modulo 16 with no bubble at the wrap boundary.
REQ-023 SHALL, on flush, clear all occupied bits, head=tail=0, count=0, retired.valid=0 next cycle; flush SHALL override same-cycle allocate, complete and retire.

Reset
REQ-024 SHALL on reset set head=0, tail=0, count=0, all occupied/resultsReady=0, retired=0, storeCommit=0, storeCommitTag=0.
REQ-025 SHALL have reset take priority over flush and all other inputs; reset mid-operation drops all entries.

Configuration
REQ-026 SHALL, with ROB_STORE_COMMIT_EN defined, pulse storeCommit=1 for one cycle with storeCommitTag = retiring ageTag when a store entry retires, aligned with the retired register update.
REQ-027 SHALL, without ROB_STORE_COMMIT_EN, omit storeCommit/storeCommitTag; store entries retire silently.

Verification
REQ-028 Reset, allocate PC=0x100 rd=5 tag 0, complete tag 0 with 0xDEADBEEF -> retired {0xDEADBEEF, 5, valid=1} exactly 2 cycles after completion.
REQ-029 Allocate tags 0,1,2; complete 2, then 1, then 0 -> retires strictly in order 0,1,2 on consecutive cycles.
REQ-030 Fill 16 entries -> allocateReady=0, 17th confirm ignored; retire one -> allocateReady=1, next allocate gets tag 0 after wrap.
REQ-031 Upper and lower both complete tag 3 in one cycle (0x11 vs 0x22) -> retired result 0x11.
REQ-032 Store at tag 4 with ROB_STORE_COMMIT_EN, completed -> retired.valid=0, storeCommit=1, storeCommitTag=4 for one cycle.
REQ-033 Eight entries in flight, flush with concurrent allocate -> count=0, nextAgeTag=0, no retired.valid thereafter.
